// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit driving a word-addressed RAM with one-cycle registered reads.
// Sub-word stores are done as read-modify-write over the ADDR/DATA states.
module riscv_lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic [31:0] ram_adress,
    output logic [31:0] data_out_ram,
    output logic        ram_enable_write,
    input  logic [31:0] data_in_ram
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic        write_q, write_d;
    logic [31:0] adr_q, adr_d, dout_q, dout_d, rdata_q, rdata_d;
    logic        we_q, we_d, rv_q, rv_d, re_q, re_d;
    logic        legal, mis, err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_val, merged;

    assign req_ready        = state_q == IDLE;
    assign ram_adress       = adr_q;
    assign data_out_ram     = dout_q;
    assign ram_enable_write = we_q;
    assign resp_valid       = rv_q;
    assign resp_error       = re_q;
    assign resp_rdata       = rdata_q;

    assign legal = req_write ? req_funct3 <= 3'd2 : !(req_funct3 == 3'd3 || req_funct3 >= 3'd6);
    assign mis   = (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) || (req_funct3[1:0] == 2'd1 && req_addr[0]);
    assign err   = !legal || mis;

    assign rd_byte = data_in_ram[{lane_q, 3'b000} +: 8];
    assign rd_half = data_in_ram[{lane_q[1], 4'b0000} +: 16];
    assign ld_val  = f3_q == 3'd0 ? {{24{rd_byte[7]}}, rd_byte} :
                     f3_q == 3'd4 ? {24'h0, rd_byte} :
                     f3_q == 3'd1 ? {{16{rd_half[15]}}, rd_half} :
                     f3_q == 3'd5 ? {16'h0, rd_half} : data_in_ram;

    // Replace only the addressed lane of the word just read back.
    always_comb begin
        merged = data_in_ram;
        if (f3_q[0])
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        wdata_d = wdata_q;
        write_d = write_q;
        adr_d   = adr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        we_d    = 1'b0;
        rv_d    = 1'b0;
        re_d    = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                if (err) begin
                    rv_d    = 1'b1;
                    re_d    = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    adr_d   = {2'b00, req_addr[31:2]};
                    f3_d    = req_funct3;
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata[15:0];
                    write_d = req_write;
                    if (req_write && req_funct3 == 3'd2) begin
                        dout_d  = req_wdata;
                        we_d    = 1'b1;
                        rv_d    = 1'b1;
                        rdata_d = 32'h0;
                    end else
                        state_d = ADDR;
                end
            end
            ADDR: state_d = DATA;
            DATA: begin
                state_d = IDLE;
                rv_d    = 1'b1;
                rdata_d = write_q ? 32'h0 : ld_val;
                dout_d  = write_q ? merged : dout_q;
                we_d    = write_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            f3_q    <= 3'd0;
            lane_q  <= 2'd0;
            wdata_q <= 16'h0;
            write_q <= 1'b0;
            adr_q   <= 32'h0;
            dout_q  <= 32'h0;
            rdata_q <= 32'h0;
            we_q    <= 1'b0;
            rv_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            adr_q   <= adr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            rv_q    <= rv_d;
            re_q    <= re_d;
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed vector table plus hand-written SW burst and mid-operation reset sequences.
module tb_riscv_lsu;
    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_write = 0;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_error, ram_enable_write;
    logic [31:0] resp_rdata, ram_adress, data_out_ram, data_in_ram;

    logic [31:0] mem [16];
    logic [31:0] rd_q = 0;
    logic        tb_we = 0;
    logic [3:0]  tb_a = 0;
    logic [31:0] tb_d = 0;
    int          wr_cnt = 0, rv_cnt = 0, re_cnt = 0;
    int          checks = 0, errors = 0;

    riscv_lsu dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .ram_adress(ram_adress), .data_out_ram(data_out_ram),
        .ram_enable_write(ram_enable_write), .data_in_ram(data_in_ram)
    );

    always #5 clk = ~clk;

    assign data_in_ram = rd_q;
    always @(posedge clk) begin
        if (tb_we) mem[tb_a] <= tb_d;
        else if (ram_enable_write) mem[ram_adress[3:0]] <= data_out_ram;
        rd_q <= mem[ram_adress[3:0]];
        if (ram_enable_write) wr_cnt <= wr_cnt + 1;
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (resp_error) re_cnt <= re_cnt + 1;
    end

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_wr;
        int          chk_idx;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1; tb_a = a; tb_d = d;
        @(negedge clk);
        tb_we = 0;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd, output int wrs);
        int w0;
        @(negedge clk);
        w0 = wr_cnt;
        req_valid = 1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_funct3 = 3'd7;
        lat = 99; err = 1'bx; rd = 32'hx;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; err = resp_error; rd = resp_rdata;
                break;
            end
        end
        @(posedge clk);
        #1 wrs = wr_cnt - w0;
    endtask

    initial begin
        int lat, wrs, w0, r0, e0;
        logic err;
        logic [31:0] rd;
        vecs[0]  = '{0, 3'd0, 32'h11, 0,            0, 32'hFFFFFFAA, 3, 0, -1, 0};
        vecs[1]  = '{0, 3'd4, 32'h11, 0,            0, 32'h000000AA, 3, 0, -1, 0};
        vecs[2]  = '{0, 3'd1, 32'h12, 0,            0, 32'hFFFF8899, 3, 0, -1, 0};
        vecs[3]  = '{0, 3'd5, 32'h12, 0,            0, 32'h00008899, 3, 0, -1, 0};
        vecs[4]  = '{0, 3'd2, 32'h10, 0,            0, 32'h8899AABB, 3, 0, -1, 0};
        vecs[5]  = '{0, 3'd0, 32'h10, 0,            0, 32'hFFFFFFBB, 3, 0, -1, 0};
        vecs[6]  = '{0, 3'd1, 32'h10, 0,            0, 32'hFFFFAABB, 3, 0, -1, 0};
        vecs[7]  = '{1, 3'd0, 32'h0B, 32'hDEADBEEF, 0, 32'h0,        3, 1,  2, 32'hEF223344};
        vecs[8]  = '{1, 3'd1, 32'h08, 32'h0000CAFE, 0, 32'h0,        3, 1,  2, 32'hEF22CAFE};
        vecs[9]  = '{0, 3'd2, 32'h13, 0,            1, 32'h0,        1, 0,  4, 32'h8899AABB};
        vecs[10] = '{1, 3'd1, 32'h01, 32'h0000FFFF, 1, 32'h0,        1, 0,  0, 32'h0};
        vecs[11] = '{0, 3'd3, 32'h10, 0,            1, 32'h0,        1, 0,  4, 32'h8899AABB};
        vecs[12] = '{1, 3'd4, 32'h10, 32'h12345678, 1, 32'h0,        1, 0,  4, 32'h8899AABB};
        vecs[13] = '{0, 3'd2, 32'h08, 0,            0, 32'hEF22CAFE, 3, 0, -1, 0};

        #2;
        check("reset ram_adress", ram_adress, 0);
        check("reset data_out_ram", data_out_ram, 0);
        check("reset resp_rdata", resp_rdata, 0);
        check("reset pulses", {29'h0, ram_enable_write, resp_valid, resp_error}, 0);
        check("reset req_ready", {31'h0, req_ready}, 1);
        for (int i = 0; i < 16; i++) poke(i[3:0], 32'h0);
        poke(4'd4, 32'h8899AABB);
        poke(4'd2, 32'h11223344);
        @(negedge clk) reset = 0;

        foreach (vecs[i]) begin
            issue(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rd, wrs);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d resp_error", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
            check($sformatf("v%0d resp_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d writes", i), wrs, vecs[i].exp_wr);
            if (!vecs[i].exp_err)
                check($sformatf("v%0d ram_adress", i), ram_adress, {2'b00, vecs[i].addr[31:2]});
            if (vecs[i].chk_idx >= 0)
                check($sformatf("v%0d mem", i), mem[vecs[i].chk_idx], vecs[i].chk_val);
        end

        // Three SW in consecutive cycles.
        @(negedge clk);
        w0 = wr_cnt; r0 = rv_cnt; e0 = re_cnt;
        req_valid = 1; req_write = 1; req_funct3 = 3'd2; req_wdata = 32'h12345678;
        for (int k = 0; k < 3; k++) begin
            req_addr = 32'h20 + 32'(4 * k);
            @(posedge clk);
            #1;
        end
        req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("sw burst writes", wr_cnt - w0, 3);
        check("sw burst resp_valid", rv_cnt - r0, 3);
        check("sw burst resp_error", re_cnt - e0, 0);
        check("sw burst mem8", mem[8], 32'h12345678);
        check("sw burst mem9", mem[9], 32'h12345678);
        check("sw burst mem10", mem[10], 32'h12345678);

        // SB aborted by reset during DATA.
        @(negedge clk);
        w0 = wr_cnt; r0 = rv_cnt;
        req_valid = 1; req_write = 1; req_funct3 = 3'd0; req_addr = 32'h0B; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        check("addr req_ready low", {31'h0, req_ready}, 0);
        @(negedge clk);
        check("data req_ready low", {31'h0, req_ready}, 0);
        reset = 1;
        #1;
        check("abort ram_adress", ram_adress, 0);
        check("abort data_out_ram", data_out_ram, 0);
        check("abort pulses", {29'h0, ram_enable_write, resp_valid, resp_error}, 0);
        check("abort req_ready", {31'h0, req_ready}, 1);
        @(negedge clk) reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check("abort writes", wr_cnt - w0, 0);
        check("abort resp_valid", rv_cnt - r0, 0);
        check("abort mem2", mem[2], 32'hEF22CAFE);
        issue(1'b0, 3'd2, 32'h10, 32'h0, lat, err, rd, wrs);
        check("post-reset lw latency", lat, 3);
        check("post-reset lw rdata", rd, 32'h8899AABB);
        check("post-reset lw error", {31'h0, err}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
